// File: rtl/accum_ser_pkg.sv
// Shared types and default geometry for the accum_ser bit-serial operand sequencer.
package accum_ser_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    ACCUM = 2'd2
  } state_e;

  localparam int WORD_W_DEF = 16;
  localparam int N_ZERO_DEF = 6;
  localparam int N_POLE_DEF = 2;
  localparam int LAST_BIT   = WORD_W_DEF - 1;

endpackage

// File: rtl/accum_ser_piso.sv
// Parallel-in serial-out shifter: loads a term, then shifts it out LSB-first with zero fill.
module accum_ser_piso
  import accum_ser_pkg::*;
#(
  parameter int W = WORD_W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         so
);

  logic [W-1:0] sr_r;

  // Load has priority; zero fill leaves the register empty once a term is fully sent.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_r <= '0;
    end else if (load) begin
      sr_r <= din;
    end else if (shift) begin
      sr_r <= {1'b0, sr_r[W-1:1]};
    end else begin
      sr_r <= sr_r;
    end
  end

  assign so = sr_r[0];

endmodule

// File: rtl/accum_ser.sv
// Bit-serial term sequencer driving the ACCUM serial accumulator and its capture strobes.
// Optional stall reporting (stall_err, idle_frames) is enabled by ACCUM_SER_STALL_ERR_EN.
module accum_ser
  import accum_ser_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int N_ZERO = N_ZERO_DEF,
  parameter int N_POLE = N_POLE_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              term_valid,
  input  logic [WORD_W-1:0] term_data,
  output logic              term_ready,
  output logic              a,
  output logic              m1_sel,
  output logic              m2_sel,
  output logic              sezi_en,
  output logic              sei_en,
  output logic              busy,
  output logic              done
`ifdef ACCUM_SER_STALL_ERR_EN
  ,
  output logic              stall_err,
  output logic [7:0]        idle_frames
`endif
);

  localparam int N_TERMS = N_ZERO + N_POLE;
  localparam int CW      = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int TW      = $clog2(N_TERMS + 1);
  localparam logic [CW-1:0] LAST_C    = CW'(WORD_W - 1);
  localparam logic [TW-1:0] N_ZERO_C  = TW'(N_ZERO);
  localparam logic [TW-1:0] N_TERMS_C = TW'(N_TERMS);

  state_e        state_r, state_nx_s;
  logic [CW-1:0] cnt_r, cnt_nx_s;
  logic [TW-1:0] tcnt_r, tcnt_nx_s;
  logic [TW:0]   pend_s;
  logic          term_frame_r, term_frame_nx_s;
  logic          fire_sezi_r, fire_sezi_nx_s;
  logic          fire_sei_r, fire_sei_nx_s;
  logic          frame_end_s, load_s, go_s, slot_nx_s, m1_nx_s, m2_nx_s;

  accum_ser_piso #(.W(WORD_W)) u_piso (
    .clk   (clk),
    .reset (reset),
    .load  (load_s),
    .shift (state_r != IDLE),
    .din   (term_data),
    .so    (a)
  );

  // Next-state decode; outputs are then registered from these next values.
  always_comb begin
    frame_end_s = (state_r != IDLE) && (cnt_r == LAST_C);
    load_s      = term_ready && term_valid;
    go_s        = (state_r == IDLE) && start && !done;

    case (state_r)
      IDLE:    state_nx_s = go_s ? CLEAR : IDLE;
      CLEAR:   state_nx_s = frame_end_s ? ACCUM : CLEAR;
      ACCUM:   state_nx_s = fire_sei_r ? IDLE : ACCUM;
      default: state_nx_s = IDLE;
    endcase

    if ((state_r == IDLE) || (state_nx_s == IDLE) || frame_end_s) begin
      cnt_nx_s = '0;
    end else begin
      cnt_nx_s = cnt_r + CW'(1);
    end

    if (go_s) begin
      tcnt_nx_s = '0;
    end else if (frame_end_s && term_frame_r) begin
      tcnt_nx_s = tcnt_r + TW'(1);
    end else begin
      tcnt_nx_s = tcnt_r;
    end

    if (frame_end_s) begin
      term_frame_nx_s = load_s;
    end else if (state_nx_s == IDLE) begin
      term_frame_nx_s = 1'b0;
    end else begin
      term_frame_nx_s = term_frame_r;
    end

    fire_sezi_nx_s = frame_end_s &&
                     ((term_frame_r && (tcnt_nx_s == N_ZERO_C)) ||
                      ((state_r == CLEAR) && (N_ZERO == 0)));
    fire_sei_nx_s  = frame_end_s && term_frame_r && (tcnt_nx_s == N_TERMS_C);

    // A term already in flight counts as consumed, so no slot opens after the last one.
    pend_s    = {1'b0, tcnt_nx_s} + {{TW{1'b0}}, term_frame_nx_s};
    slot_nx_s = (state_nx_s != IDLE) && (cnt_nx_s == LAST_C) && (pend_s < {1'b0, N_TERMS_C});

    case (state_nx_s)
      IDLE:    begin m1_nx_s = 1'b0; m2_nx_s = 1'b0; end
      CLEAR:   begin m1_nx_s = 1'b1; m2_nx_s = 1'b1; end
      ACCUM:   begin
        m1_nx_s = term_frame_nx_s ? (cnt_nx_s == LAST_C) : 1'b1;
        m2_nx_s = 1'b0;
      end
      default: begin m1_nx_s = 1'b0; m2_nx_s = 1'b0; end
    endcase
  end

  // Sequencer state, counters and registered control outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      cnt_r        <= '0;
      tcnt_r       <= '0;
      term_frame_r <= 1'b0;
      fire_sezi_r  <= 1'b0;
      fire_sei_r   <= 1'b0;
      m1_sel       <= 1'b0;
      m2_sel       <= 1'b0;
      term_ready   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state_r      <= state_nx_s;
      cnt_r        <= cnt_nx_s;
      tcnt_r       <= tcnt_nx_s;
      term_frame_r <= term_frame_nx_s;
      fire_sezi_r  <= fire_sezi_nx_s;
      fire_sei_r   <= fire_sei_nx_s;
      m1_sel       <= m1_nx_s;
      m2_sel       <= m2_nx_s;
      term_ready   <= slot_nx_s;
      busy         <= (state_nx_s != IDLE);
      done         <= (state_r == ACCUM) && fire_sei_r;
    end
  end

  // Capture strobes launch on the falling edge so ACCUM samples mid-cycle.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      sezi_en <= 1'b0;
      sei_en  <= 1'b0;
    end else begin
      sezi_en <= fire_sezi_r;
      sei_en  <= fire_sei_r;
    end
  end

`ifdef ACCUM_SER_STALL_ERR_EN
  // Stall reporting: pulse per empty load slot plus a saturating idle-frame tally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_err   <= 1'b0;
      idle_frames <= 8'd0;
    end else begin
      stall_err <= term_ready && !term_valid;
      if (go_s) begin
        idle_frames <= 8'd0;
      end else if (term_ready && !term_valid && (idle_frames != 8'hFF)) begin
        idle_frames <= idle_frames + 8'd1;
      end else begin
        idle_frames <= idle_frames;
      end
    end
  end
`endif

endmodule
